// File: rtl/td4_sequencer.sv
// Fetch/execute controller for the 4-bit TD4 core: fetches over req/ack, holds the IR,
// and opens the decoder's active-low load enables for exactly one EXEC cycle per instruction.
module td4_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step,
  input  logic [ADDR_W-1:0] pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [7:0]        imem_data,
  output logic [3:0]        dec_opcode,
  output logic [3:0]        dec_imm,
  input  logic [3:0]        load_in,
  output logic [3:0]        load_out,
  output logic              busy,
  output logic              halted,
  output logic              err_illegal,
  output logic              err_timeout,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_e;

  localparam logic [7:0] TimeoutLim = 8'(TIMEOUT);

  state_e             state_q, state_d;
  logic [7:0]         ir_q, ir_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               reload_q, reload_d;
  logic               step_mode_q, step_mode_d;
  logic [7:0]         tcnt_q, tcnt_d;
  logic [7:0]         tcnt_inc;
  logic               err_ill_q, err_ill_d;
  logic               err_to_q, err_to_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal;
  logic               self_jump;
  logic [ADDR_W-1:0]  imm_ext;

  assign imm_ext   = ADDR_W'(ir_q[3:0]);
  assign illegal   = (ir_q[7:4] == 4'h8) || (ir_q[7:4] == 4'hA) ||
                     (ir_q[7:4] == 4'hC) || (ir_q[7:4] == 4'hD);
  assign self_jump = (ir_q[7:4] == 4'hF) && (imm_ext == pc);
  assign tcnt_inc  = tcnt_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    addr_d      = addr_q;
    reload_d    = 1'b0;
    step_mode_d = step_mode_q;
    tcnt_d      = tcnt_q;
    err_ill_d   = err_ill_q;
    err_to_d    = err_to_q;
    cnt_d       = cnt_q;
    imem_req    = 1'b0;
    imem_addr   = addr_q;
    load_out    = 4'b1111;

    case (state_q)
      IDLE: begin
        if (run || step) begin
          state_d     = FETCH;
          addr_d      = pc;
          tcnt_d      = 8'd0;
          step_mode_d = !run && step;
        end
      end
      FETCH: begin
        imem_req = 1'b1;
        // After EXEC the datapath PC only settles now, so pass it through while latching it.
        if (reload_q) begin
          imem_addr = pc;
          addr_d    = pc;
        end
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = EXEC;
        end else begin
          tcnt_d = tcnt_inc;
          if (tcnt_inc == TimeoutLim) begin
            err_to_d = 1'b1;
            state_d  = HALT;
          end
        end
      end
      EXEC: begin
        if (illegal) begin
          err_ill_d = 1'b1;
          state_d   = HALT;
        end else begin
          load_out = load_in;
          cnt_d    = cnt_q + CNT_W'(1);
          if (self_jump) begin
            state_d = HALT;
          end else if (run && !step_mode_q) begin
            state_d  = FETCH;
            reload_d = 1'b1;
            tcnt_d   = 8'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ir_q        <= 8'h00;
      addr_q      <= '0;
      reload_q    <= 1'b0;
      step_mode_q <= 1'b0;
      tcnt_q      <= 8'd0;
      err_ill_q   <= 1'b0;
      err_to_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      addr_q      <= addr_d;
      reload_q    <= reload_d;
      step_mode_q <= step_mode_d;
      tcnt_q      <= tcnt_d;
      err_ill_q   <= err_ill_d;
      err_to_q    <= err_to_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dec_opcode  = ir_q[7:4];
  assign dec_imm     = ir_q[3:0];
  assign busy        = (state_q == FETCH) || (state_q == EXEC);
  assign halted      = (state_q == HALT);
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_td4_sequencer.sv
// Bench for td4_sequencer: plays program memory and datapath PC, and compares every cycle
// against a cycle-level reference of the fetch/execute rules plus directed end-state checks.
module tb_td4_sequencer;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       reset, run, step, imem_ack;
  logic [3:0] pc, load_in, load_out, dec_opcode, dec_imm, imem_addr;
  logic [7:0] imem_data, instr_count;
  logic       imem_req, busy, halted, err_illegal, err_timeout;

  td4_sequencer #(.ADDR_W(4), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .run(run), .step(step), .pc(pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .dec_opcode(dec_opcode), .dec_imm(dec_imm), .load_in(load_in), .load_out(load_out),
    .busy(busy), .halted(halted), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef enum int {M_IDLE, M_FETCH, M_EXEC, M_HALT} phase_e;

  phase_e     mPhase;
  logic [7:0] mIr;
  logic [3:0] mAddr, mPc;
  bit         mStepMode, mErrI, mErrT, mValid;
  int         mWait, mCount;
  logic [7:0] mem [16];
  int         nChecks, nPass;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic bit isIllegal(input logic [3:0] op);
    return op inside {4'h8, 4'hA, 4'hC, 4'hD};
  endfunction

  // TD4 decoder destinations: A=1110, B=1101, OUT=1011, PC=0111 (carry taken as clear)
  function automatic logic [3:0] decodeLoad(input logic [7:0] ir);
    case (ir[7:4])
      4'h0, 4'h1, 4'h2, 4'h3: return 4'b1110;
      4'h4, 4'h5, 4'h6, 4'h7: return 4'b1101;
      4'h9, 4'hB:             return 4'b1011;
      4'hE, 4'hF:             return 4'b0111;
      default:                return 4'($urandom);
    endcase
  endfunction

  task automatic modelReset();
    mPhase = M_IDLE; mIr = 8'h00; mAddr = 4'h0; mPc = 4'h0;
    mStepMode = 1'b0; mErrI = 1'b0; mErrT = 1'b0; mWait = 0; mCount = 0;
  endtask

  task automatic applyStimulus(input bit rst, input bit r, input bit s, input bit a);
    logic [3:0] expLoad;
    logic [3:0] oldPc;
    @(negedge clk);
    reset = rst; run = r; step = s; imem_ack = a;
    pc = mPc;
    imem_data = (mPhase == M_FETCH) ? mem[mAddr] : 8'($urandom);
    load_in   = (mPhase == M_EXEC) ? decodeLoad(mIr) : 4'($urandom);
    #1;
    expLoad = (mPhase == M_EXEC && !isIllegal(mIr[7:4])) ? load_in : 4'hF;
    if (mValid) begin
      checkOutput("imem_req", 32'(imem_req), 32'(mPhase == M_FETCH));
      if (mPhase == M_FETCH) checkOutput("imem_addr", 32'(imem_addr), 32'(mAddr));
      checkOutput("load_out", 32'(load_out), 32'(expLoad));
      checkOutput("busy", 32'(busy), 32'(mPhase == M_FETCH || mPhase == M_EXEC));
      checkOutput("halted", 32'(halted), 32'(mPhase == M_HALT));
      checkOutput("err_illegal", 32'(err_illegal), 32'(mErrI));
      checkOutput("err_timeout", 32'(err_timeout), 32'(mErrT));
      checkOutput("instr_count", 32'(instr_count), 32'(mCount));
      checkOutput("dec_opcode", 32'(dec_opcode), 32'(mIr[7:4]));
      checkOutput("dec_imm", 32'(dec_imm), 32'(mIr[3:0]));
    end
    if (rst) begin
      modelReset();
      mValid = 1'b1;
    end else begin
      case (mPhase)
        M_IDLE: if (r || s) begin
          mPhase = M_FETCH; mAddr = mPc; mWait = 0; mStepMode = !r && s;
        end
        M_FETCH: if (a) begin
          mIr = imem_data; mPhase = M_EXEC;
        end else begin
          mWait++;
          if (mWait == TIMEOUT) begin mErrT = 1'b1; mPhase = M_HALT; end
        end
        M_EXEC: if (isIllegal(mIr[7:4])) begin
          mErrI = 1'b1; mPhase = M_HALT;
        end else begin
          mCount = (mCount + 1) % 256;
          oldPc = mPc;
          mPc = (expLoad[3] == 1'b0) ? mIr[3:0] : 4'(mPc + 4'd1);
          if (mIr[7:4] == 4'hF && mIr[3:0] == oldPc) mPhase = M_HALT;
          else if (r && !mStepMode) begin mPhase = M_FETCH; mAddr = mPc; mWait = 0; end
          else mPhase = M_IDLE;
        end
        default: mPhase = M_HALT;
      endcase
    end
  endtask

  task automatic fillMem(input logic [7:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  initial begin
    logic [7:0] reqBits;
    int reqCount;
    nChecks = 0; nPass = 0; mValid = 1'b0;
    modelReset();
    reset = 1'b1; run = 1'b0; step = 1'b0; imem_ack = 1'b0;
    pc = 4'h0; imem_data = 8'h00; load_in = 4'hF;

    // Free run of MOV A,5 / ADD A,1 / JMP 2 with zero-wait ack; the JMP lands on itself
    fillMem(8'h01); mem[0] = 8'h35; mem[1] = 8'h01; mem[2] = 8'hF2;
    applyStimulus(1, 0, 0, 0);
    reqBits = 8'h00;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 1, 0, 1);
      reqBits[i] = imem_req;
    end
    checkOutput("run_req_cycles", 32'(reqBits), 32'h2A);
    checkOutput("run_halted", 32'(halted), 32'd1);
    checkOutput("run_count", 32'(instr_count), 32'd3);

    // Two step pulses while stopped, ack always offered
    fillMem(8'h01); mem[0] = 8'h3A;
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, i == 0, 1);
    checkOutput("step1_count", 32'(instr_count), 32'd1);
    checkOutput("step1_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) applyStimulus(0, 0, i == 0, 1);
    checkOutput("step2_count", 32'(instr_count), 32'd2);
    checkOutput("step2_busy", 32'(busy), 32'd0);

    // Ack withheld until the timeout fires
    applyStimulus(1, 0, 0, 0);
    reqCount = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, 0);
      reqCount += int'(imem_req);
    end
    checkOutput("to_req_cycles", 32'(reqCount), 32'd15);
    checkOutput("to_err", 32'(err_timeout), 32'd1);
    checkOutput("to_halted", 32'(halted), 32'd1);
    checkOutput("to_load_out", 32'(load_out), 32'hF);

    // Ack arriving on the 15th FETCH cycle beats the timeout; run is dropped during FETCH
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      applyStimulus(0, i == 0, 0, mPhase == M_FETCH && mWait == TIMEOUT - 1);
    checkOutput("late_ack_err", 32'(err_timeout), 32'd0);
    checkOutput("late_ack_count", 32'(instr_count), 32'd1);

    // Illegal opcode halts; later run/step/ack are ignored
    mem[0] = 8'h80;
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 1);
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom));
    checkOutput("ill_err", 32'(err_illegal), 32'd1);
    checkOutput("ill_halted", 32'(halted), 32'd1);
    checkOutput("ill_count", 32'(instr_count), 32'd0);

    // Reset coinciding with ack mid-FETCH, from a non-zero address
    fillMem(8'h01); mem[1] = 8'h3F;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("rst_ack_opcode", 32'(dec_opcode), 32'h0);
    checkOutput("rst_ack_addr", 32'(imem_addr), 32'h0);
    checkOutput("rst_ack_busy", 32'(busy), 32'd0);
    checkOutput("rst_ack_count", 32'(instr_count), 32'd0);

    // Run dropped mid-FETCH: instruction still retires, then idle
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1);
    checkOutput("drop_run_count", 32'(instr_count), 32'd1);
    checkOutput("drop_run_busy", 32'(busy), 32'd0);

    // 256 retirements of ADD A,1 / JMP 0 wrap the counter
    fillMem(8'h01); mem[1] = 8'hF0;
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 514; i++) applyStimulus(0, 1, 0, 1);
    checkOutput("wrap_count", 32'(instr_count), 32'd0);
    checkOutput("wrap_flags", 32'({err_illegal, err_timeout, halted}), 32'd0);

    // Random programs and controls with occasional reset
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    applyStimulus(1, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      bit rst;
      rst = ($urandom_range(0, 39) == 0);
      if (rst) for (int j = 0; j < 16; j++) mem[j] = 8'($urandom);
      applyStimulus(rst, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/td4_sequencer.md
Name: td4_sequencer

Overview:
Multi-cycle fetch/execute controller for the 4-bit TD4 core. Fetches 8-bit instructions from an external program memory over a req/ack handshake and holds them in an instruction register. It presents the opcode and immediate to the combinational decoder, then gates the decoder's active-low load enables so registers A, B, OUT and PC update only during a single EXEC cycle. It also supports run/step control, halt on self-jump or illegal opcode, and a fetch timeout.

Parameters:
ADDR_W, 4, program-memory address width; equals PC width.
TIMEOUT, 15, maximum FETCH cycles without imem_ack before a timeout error; range 1..255.
CNT_W, 8, width of the retired-instruction counter.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
run  in  1  level; free-running execution while high
step  in  1  one-cycle pulse; execute exactly one instruction while stopped
pc  in  ADDR_W  current PC value from datapath
imem_req  out  1  fetch request
imem_addr  out  ADDR_W  fetch address, held stable while imem_req=1
imem_ack  in  1  fetch data valid this cycle
imem_data  in  8  instruction: [7:4] opcode, [3:0] immediate
dec_opcode  out  4  IR[7:4], to decoder data_input
dec_imm  out  4  IR[3:0], to datapath immediate
load_in  in  4  decoder load vector, active-low: bit0 A, bit1 B, bit2 OUT, bit3 PC
load_out  out  4  gated load vector to datapath, active-low
busy  out  1  high in FETCH or EXEC
halted  out  1  high in HALT
err_illegal  out  1  sticky; illegal opcode executed
err_timeout  out  1  sticky; fetch timeout
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset values: state=IDLE, IR=8'h00, imem_req=0, imem_addr=0, load_out=4'b1111, busy=0, halted=0, err_illegal=0, err_timeout=0, instr_count=0, timeout counter=0.
- Reset takes priority over every other event in any state, including mid-FETCH with ack in the same cycle. It abandons the fetch; IR is not updated.
- States: IDLE, FETCH, EXEC, HALT. load_out=4'b1111 in every state except EXEC.
- IDLE: if run=1 or step=1, go to FETCH, latch imem_addr<=pc, clear timeout counter. Record step_mode=1 when run=0 and step=1, else step_mode=0.
- FETCH: imem_req=1; imem_addr is held.
  - imem_ack=1: IR<=imem_data, go to EXEC.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no ack, set err_timeout, drop imem_req and go to HALT.
  - An ack in the same cycle the counter reaches TIMEOUT wins: capture IR, no error.
- EXEC: exactly one cycle. The datapath register update occurs at the end of this cycle.
  - Illegal opcodes are 1000, 1010, 1100 and 1101. For these: load_out=4'b1111, err_illegal<=1, instr_count unchanged, go to HALT.
  - Otherwise: load_out=load_in and instr_count<=instr_count+1, wrapping 255→0.
  - Self-jump: opcode 1111 with imm==pc. After the update, go to HALT.
  - Else if run=1 and step_mode=0: go to FETCH, latching imem_addr<=pc. This is the updated PC, visible the following cycle, so FETCH latches on its first cycle.
  - Else: go to IDLE.
- HALT: absorbing. run, step and imem_ack are ignored; halted=1. Only reset exits.
- Timing: run rises at cycle 0 → imem_req at cycle 1. Ack at cycle k → EXEC at k+1 → next imem_req at k+2. Throughput with zero-wait ack is one instruction per 2 cycles.
- run falling during FETCH: the current instruction completes, then the FSM goes to IDLE.
- step outside IDLE is ignored. step while run=1 in IDLE is treated as run.
- imem_ack outside FETCH is ignored.
- busy = (state==FETCH or state==EXEC).

Test Plan:
- Reset then run=1, program {0x35 (MOV A,5), 0x71? → use 0x01 (ADD A,1), 0xF2 (JMP 2)} with zero-wait ack → imem_req at cycles 1,3,5; load_out=1110 in EXEC of instr 0 and 1; PC 2 JMP 2 halts; halted=1, instr_count=3.
- run=0, step pulses ×2 on program 0x3A,0x01 → exactly one FETCH/EXEC per pulse, returns IDLE, busy low between; instr_count=1 then 2; no fetch without a pulse.
- FETCH with ack withheld, TIMEOUT=15 → err_timeout rises on the 15th FETCH cycle, imem_req falls, halted=1, load_out stays 1111. Repeat with ack on the 15th cycle → no error, EXEC follows.
- Fetch 0x80 (illegal) → EXEC drives load_out=1111, err_illegal=1, halted=1, instr_count unchanged; subsequent run/step/ack have no effect until reset.
- Assert reset in the same cycle as imem_ack during FETCH → next cycle IDLE, IR=0x00, all outputs at reset values; drop run mid-FETCH → instruction retires, then IDLE.
- Run 256 non-halting instructions (loop 0x01,0xF0 with pc≠imm) → instr_count wraps 255→0 with no flags set.
